// File: rtl/dbpsk_receiver_if.sv
// Symbol-side and frame-side signals of the DBPSK receiver.
//
// Handshake: sample_valid is a one-clock qualifier with no ready.
// phase_in is meaningful only on clocks where sample_valid is 1.
// The receiver consumes every strobe, including strobes on consecutive clocks.
// All outputs are single-clock pulses, except the following, which are levels:
//   - out_data and frame_len hold until they are next updated.
//   - locked is a level.
interface dbpsk_receiver_if;
  logic       sample_valid;
  logic       phase_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic [7:0] frame_len;
  logic       frame_start;
  logic       frame_end;
  logic       locked;
  logic       sync_error;

  // Sample source (bench / demod front end)
  modport master (
    output sample_valid, phase_in,
    input  out_data, out_valid, frame_len, frame_start, frame_end, locked, sync_error
  );

  // Receiver
  modport slave (
    input  sample_valid, phase_in,
    output out_data, out_valid, frame_len, frame_start, frame_end, locked, sync_error
  );
endinterface

// File: rtl/dbpsk_receiver.sv
// DBPSK differential decoder with x^7+x^4+1 self-synchronising de-whitening,
// preamble/SFD hunt and length-prefixed payload byte delivery.
module dbpsk_receiver #(
  parameter int          SYNC_ONES   = 32,
  parameter logic [15:0] SFD_WORD    = 16'hF3A0,
  parameter int          SFD_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  dbpsk_receiver_if.slave   bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {HUNT = 2'd0, SFD = 2'd1, LEN = 2'd2, PAYLOAD = 2'd3} state_t;

  localparam logic [6:0] SYNC_LAST   = 7'(SYNC_ONES - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(SFD_TIMEOUT);

  state_t      state;
  logic        prev_phase;
  logic [6:0]  hist;        // history of differential bits, hist[0] newest
  logic [6:0]  ones_cnt;
  logic [15:0] sfd_reg;
  logic [7:0]  sfd_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_sr;
  logic [7:0]  remaining;

  logic [7:0]  out_data_r;
  logic [7:0]  frame_len_r;
  logic        out_valid_r;
  logic        frame_start_r;
  logic        frame_end_r;
  logic        locked_r;
  logic        sync_error_r;

  logic        d_bit;
  logic        b_bit;
  logic [15:0] sfd_next;
  logic [7:0]  sfd_cnt_next;
  logic [7:0]  byte_next;

  // Decode the current symbol: differential bit, de-whitened bit and shifted views
  always_comb begin
    d_bit        = bus.phase_in ^ prev_phase;
    b_bit        = d_bit ^ hist[3] ^ hist[6];
    sfd_next     = {b_bit, sfd_reg[15:1]};
    sfd_cnt_next = sfd_cnt + 8'd1;
    byte_next    = {b_bit, byte_sr[7:1]};
  end

  // Frame FSM, descrambler history and registered outputs; advances on strobes only
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= HUNT;
      prev_phase    <= 1'b0;
      hist          <= '0;
      ones_cnt      <= '0;
      sfd_reg       <= '0;
      sfd_cnt       <= '0;
      bit_cnt       <= '0;
      byte_sr       <= '0;
      remaining     <= '0;
      out_data_r    <= '0;
      frame_len_r   <= '0;
      out_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      locked_r      <= 1'b0;
      sync_error_r  <= 1'b0;
    end else begin
      out_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      sync_error_r  <= 1'b0;
      if (bus.sample_valid) begin
        prev_phase <= bus.phase_in;
        hist       <= {hist[5:0], d_bit};
        case (state)
          HUNT: begin
            if (b_bit) begin
              if (ones_cnt == SYNC_LAST) begin
                locked_r <= 1'b1;
                sfd_reg  <= '0;
                sfd_cnt  <= '0;
                state    <= SFD;
              end else if (ones_cnt != 7'd127) begin
                ones_cnt <= ones_cnt + 7'd1;
              end
            end else begin
              ones_cnt <= '0;
            end
          end
          SFD: begin
            sfd_reg <= sfd_next;
            sfd_cnt <= sfd_cnt_next;
            // A match wins over a timeout landing on the same strobe
            if (sfd_next == SFD_WORD) begin
              frame_start_r <= 1'b1;
              bit_cnt       <= '0;
              byte_sr       <= '0;
              state         <= LEN;
            end else if (sfd_cnt_next == TIMEOUT_CNT) begin
              sync_error_r <= 1'b1;
              locked_r     <= 1'b0;
              ones_cnt     <= '0;
              state        <= HUNT;
            end
          end
          LEN: begin
            byte_sr <= byte_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              frame_len_r <= byte_next;
              byte_sr     <= '0;
              if (byte_next == 8'd0) begin
                frame_end_r <= 1'b1;
                locked_r    <= 1'b0;
                ones_cnt    <= '0;
                state       <= HUNT;
              end else begin
                remaining <= byte_next;
                state     <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            byte_sr <= byte_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              out_data_r  <= byte_next;
              out_valid_r <= 1'b1;
              remaining   <= remaining - 8'd1;
              byte_sr     <= '0;
              if (remaining == 8'd1) begin
                frame_end_r <= 1'b1;
                locked_r    <= 1'b0;
                ones_cnt    <= '0;
                state       <= HUNT;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.out_data    = out_data_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.frame_len   = frame_len_r;
  assign bus.frame_start = frame_start_r;
  assign bus.frame_end   = frame_end_r;
  assign bus.locked      = locked_r;
  assign bus.sync_error  = sync_error_r;
  assign dbg_state       = state;

endmodule

// File: tb/tb_dbpsk_receiver.sv
// Bench for dbpsk_receiver: a transmit-side model (whitening + DBPSK) feeds
// framed byte streams; decoded bytes are checked against the sent payload.
module tb_dbpsk_receiver;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dbpsk_receiver_if bus ();
  logic [1:0] dbg_state;

  dbpsk_receiver dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_len;

  int n_valid, n_start, n_end, n_sync, end_with_valid;
  int lock_at, sync_at;
  int strobe_n;
  logic prev_locked = 1'b0;

  // transmit-side model: self-synchronising whitener and differential modulator
  logic [6:0] tx_s;
  logic       tx_prev;
  logic       invert;
  int         gap_max;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.out_valid) begin
          n_valid++;
          check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        if (bus.frame_start) n_start++;
        if (bus.frame_end) begin
          n_end++;
          if (bus.out_valid) end_with_valid++;
          check("frame_len", 32'(bus.frame_len), 32'(exp_len));
        end
        if (bus.sync_error) begin
          n_sync++;
          sync_at = strobe_n;
        end
        if (bus.locked && !prev_locked) lock_at = strobe_n;
      end
      prev_locked = bus.locked;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    n_valid = 0; n_start = 0; n_end = 0; n_sync = 0; end_with_valid = 0;
    lock_at = -1; sync_at = -1;
  endtask

  task automatic idle(input int n);
    bus.sample_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    logic t;
    if (gap_max > 0) idle($urandom_range(gap_max, 0));
    t       = b ^ tx_s[3] ^ tx_s[6];
    tx_s    = {tx_s[5:0], t};
    tx_prev = tx_prev ^ t;
    bus.phase_in     = tx_prev ^ invert;
    bus.sample_valid = 1'b1;
    @(posedge clock);
    #1;
    strobe_n++;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  // Sends preamble, SFD, length and the first n_send payload bytes.
  // Only bytes actually sent are expected.
  task automatic send_frame(input int ones, input logic [7:0] len,
                            input logic [7:0] pl[$], input int n_send);
    logic [15:0] sfd;
    sfd     = 16'hF3A0;
    exp_len = len;
    for (int i = 0; i < n_send; i++) exp_q.push_back(pl[i]);
    for (int i = 0; i < ones; i++) send_bit(1'b1);
    for (int i = 0; i < 16; i++) send_bit(sfd[i]);
    send_byte(len);
    for (int i = 0; i < n_send; i++) send_byte(pl[i]);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.sample_valid = 1'b0;
    bus.phase_in     = 1'b0;
    tx_s     = '0;
    tx_prev  = 1'b0;
    strobe_n = 0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {bus.out_data, bus.out_valid, bus.frame_len, bus.frame_start,
                bus.frame_end, bus.locked, bus.sync_error, dbg_state}, 32'd0);
  endtask

  task automatic random_frame(input int gaps);
    logic [7:0] pl[$];
    logic [7:0] len;
    len = 8'($urandom_range(5, 1));
    pl.delete();
    for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom_range(255, 0)));
    clear_counts();
    gap_max = gaps;
    send_frame(64, len, pl, int'(len));
    idle(4);
    check("rnd_start", n_start, 1);
    check("rnd_valid", n_valid, int'(len));
    check("rnd_end_with_byte", end_with_valid, 1);
    check("rnd_q_empty", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] pl[$];
    invert  = 1'b0;
    gap_max = 0;
    clear_counts();
    do_reset();
    check_outputs_zero("reset_outputs");

    // Basic frame, back-to-back strobes
    pl = '{8'hA5, 8'h00, 8'hFF};
    clear_counts();
    send_frame(64, 8'h03, pl, 3);
    idle(4);
    check("basic_lock_at", lock_at, 32);
    check("basic_start", n_start, 1);
    check("basic_valid", n_valid, 3);
    check("basic_end", n_end, 1);
    check("basic_end_with_byte", end_with_valid, 1);
    check("basic_locked_low", 32'(bus.locked), 32'd0);
    check("basic_frame_len", 32'(bus.frame_len), 32'h03);

    // Same frame with random idle clocks between strobes
    clear_counts();
    gap_max = 5;
    send_frame(64, 8'h03, pl, 3);
    idle(4);
    check("gap_start", n_start, 1);
    check("gap_valid", n_valid, 3);
    check("gap_end", n_end, 1);
    check("gap_end_with_byte", end_with_valid, 1);
    check("gap_sync", n_sync, 0);

    // SFD timeout: 40 ones then 64 zero bits, no SFD
    gap_max = 0;
    do_reset();
    clear_counts();
    for (int i = 0; i < 40; i++) send_bit(1'b1);
    for (int i = 0; i < 64; i++) send_bit(1'b0);
    idle(4);
    check("to_sync_count", n_sync, 1);
    check("to_sync_at", sync_at, 32 + 64);
    check("to_locked_low", 32'(bus.locked), 32'd0);
    check("to_no_start", n_start, 0);
    random_frame(0);

    // Zero-length frame
    pl.delete();
    clear_counts();
    send_frame(64, 8'h00, pl, 0);
    idle(4);
    check("zl_start", n_start, 1);
    check("zl_end", n_end, 1);
    check("zl_valid", n_valid, 0);
    check("zl_frame_len", 32'(bus.frame_len), 32'h00);

    // Whole stream phase-inverted
    do_reset();
    invert = 1'b1;
    random_frame(3);
    random_frame(0);
    invert = 1'b0;

    // Reset in the middle of the payload
    pl = '{8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0))};
    clear_counts();
    send_frame(64, 8'h03, pl, 1);
    send_bit(pl[1][0]);
    send_bit(pl[1][1]);
    send_bit(pl[1][2]);
    bus.sample_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("async_reset_outputs");
    check("mid_bytes_before_reset", n_valid, 1);
    do_reset();
    idle(3);
    check("mid_no_end", n_end, 0);
    random_frame(0);

    // Further randomized frames
    for (int k = 0; k < 4; k++) random_frame(int'($urandom_range(3, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time
  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: got=timeout expected=completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
